// File: rtl/demux_l2_deserializer.sv
// rtl/demux_l2_deserializer.sv - 4-lane frame deserializer with lane-0 sync lock
//
// Receive side of the two-level 4:1 mux tree. One 9-bit word {valid, data}
// arrives per clk4f cycle. Lane 0 is found by a sync word. Once locked, four
// consecutive words are rebuilt into one frame, which is presented with a
// single-cycle strobe.
//
// Ports:
//   clk4f          in   serial word clock, rising edge
//   reset_L        in   asynchronous active-low reset
//   in_data[8:0]   in   serialized word, bit 8 = valid, bits 7:0 = data
//   out_data0..3   out  reassembled lane 0..3 words, held between strobes
//   out_valid      out  one-cycle strobe: a new frame is on out_data0..3
//   aligned        out  high while locked to the lane-0 sync word

module demux_l2_deserializer #(
    parameter logic [7:0] SYNC_WORD  = 8'hC0,
    parameter int         MISS_LIMIT = 2
) (
    input  logic       clk4f,
    input  logic       reset_L,
    input  logic [8:0] in_data,
    output logic [8:0] out_data0,
    output logic [8:0] out_data1,
    output logic [8:0] out_data2,
    output logic [8:0] out_data3,
    output logic       out_valid,
    output logic       aligned
);

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    localparam logic [2:0] MISS_LIM3 = 3'(MISS_LIMIT);

    state_t     state_q,     state_d;
    logic [1:0] slot_q,      slot_d;
    logic [2:0] miss_q,      miss_d;
    logic [8:0] shadow0_q,   shadow0_d;
    logic [8:0] shadow1_q,   shadow1_d;
    logic [8:0] shadow2_q,   shadow2_d;
    logic [8:0] out_data0_q, out_data0_d;
    logic [8:0] out_data1_q, out_data1_d;
    logic [8:0] out_data2_q, out_data2_d;
    logic [8:0] out_data3_q, out_data3_d;
    logic       out_valid_q, out_valid_d;

    logic       sync_match;
    logic [2:0] miss_inc;

    // A word whose valid bit is clear can never be a sync word.
    assign sync_match = in_data[8] && (in_data[7:0] == SYNC_WORD);
    assign miss_inc   = miss_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        miss_d      = miss_q;
        shadow0_d   = shadow0_q;
        shadow1_d   = shadow1_q;
        shadow2_d   = shadow2_q;
        out_data0_d = out_data0_q;
        out_data1_d = out_data1_q;
        out_data2_d = out_data2_q;
        out_data3_d = out_data3_q;
        out_valid_d = 1'b0;

        case (state_q)
            SEARCH: begin
                slot_d = 2'd0;
                if (sync_match) begin
                    shadow0_d = in_data;
                    slot_d    = 2'd1;
                    miss_d    = 3'd0;
                    state_d   = ALIGNED;
                end
            end

            ALIGNED: begin
                // Free-running lane counter; the stream has no stall.
                slot_d = slot_q + 2'd1;
                case (slot_q)
                    2'd0: begin
                        if (sync_match) begin
                            shadow0_d = in_data;
                            miss_d    = 3'd0;
                        end else if (miss_inc < MISS_LIM3) begin
                            // Tolerated miss: the frame is still built.
                            shadow0_d = in_data;
                            miss_d    = miss_inc;
                        end else begin
                            // Lock lost; the word is dropped so no partial
                            // frame ever reaches the outputs.
                            state_d = SEARCH;
                            slot_d  = 2'd0;
                            miss_d  = 3'd0;
                        end
                    end
                    2'd1: shadow1_d = in_data;
                    2'd2: shadow2_d = in_data;
                    default: begin
                        out_data0_d = shadow0_q;
                        out_data1_d = shadow1_q;
                        out_data2_d = shadow2_q;
                        out_data3_d = in_data;
                        out_valid_d = 1'b1;
                    end
                endcase
            end

            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            slot_q      <= 2'd0;
            miss_q      <= 3'd0;
            shadow0_q   <= 9'h000;
            shadow1_q   <= 9'h000;
            shadow2_q   <= 9'h000;
            out_data0_q <= 9'h000;
            out_data1_q <= 9'h000;
            out_data2_q <= 9'h000;
            out_data3_q <= 9'h000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            miss_q      <= miss_d;
            shadow0_q   <= shadow0_d;
            shadow1_q   <= shadow1_d;
            shadow2_q   <= shadow2_d;
            out_data0_q <= out_data0_d;
            out_data1_q <= out_data1_d;
            out_data2_q <= out_data2_d;
            out_data3_q <= out_data3_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data0 = out_data0_q;
    assign out_data1 = out_data1_q;
    assign out_data2 = out_data2_q;
    assign out_data3 = out_data3_q;
    assign out_valid = out_valid_q;
    assign aligned   = (state_q == ALIGNED);

endmodule

// File: tb/tb_demux_l2_deserializer.sv
// tb/tb_demux_l2_deserializer.sv - scoreboard bench for demux_l2_deserializer

module tb_demux_l2_deserializer;

    logic       clk4f;
    logic       reset_L;
    logic [8:0] in_data;
    logic [8:0] out_data0, out_data1, out_data2, out_data3;
    logic       out_valid;
    logic       aligned;

    int total = 0;
    int bad   = 0;

    logic [35:0] sb[$];

    demux_l2_deserializer dut (
        .clk4f     (clk4f),
        .reset_L   (reset_L),
        .in_data   (in_data),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .aligned   (aligned)
    );

    initial clk4f = 1'b0;
    always #5 clk4f = ~clk4f;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one word before the edge, return just after the edge that samples it.
    task automatic send(input logic [8:0] w);
        @(negedge clk4f);
        in_data = w;
        @(posedge clk4f);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] l0, input logic [8:0] l1,
                              input logic [8:0] l2, input logic [8:0] l3,
                              input bit expect_out);
        if (expect_out) sb.push_back({l0, l1, l2, l3});
        send(l0);
        send(l1);
        send(l2);
        send(l3);
    endtask

    // Monitor: every strobe must match the oldest expected frame.
    initial begin
        logic [35:0] exp_f;
        forever begin
            @(posedge clk4f);
            #1;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {out_data0, out_data1, out_data2, out_data3}, 36'h0);
                    total++; bad++;
                    $display("FAIL strobe_without_frame: got out_valid=1 expected 0");
                end else begin
                    exp_f = sb.pop_front();
                    chk("frame", {out_data0, out_data1, out_data2, out_data3}, exp_f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_L = 1'b0;
        in_data = 9'h100;

        // 1. Held in reset: everything stays cleared.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk4f);
            #1;
            chk("rst_aligned", 36'(aligned), 36'h0);
            chk("rst_valid", 36'(out_valid), 36'h0);
            chk("rst_data", {out_data0, out_data1, out_data2, out_data3}, 36'h0);
        end
        @(negedge clk4f);
        reset_L = 1'b1;

        // 2. First lock and frame.
        send(9'h1C0);
        chk("lock_aligned", 36'(aligned), 36'h1);
        sb.push_back({9'h1C0, 9'h102, 9'h101, 9'h100});
        send(9'h102);
        send(9'h101);
        send(9'h100);

        // 3. Back-to-back frames, valid=0 word passes through.
        send_frame(9'h1C0, 9'h101, 9'h102, 9'h103, 1'b1);
        send_frame(9'h1C0, 9'h102, 9'h101, 9'h100, 1'b1);
        send_frame(9'h1C0, 9'h000, 9'h1FF, 9'h055, 1'b1);

        // 4. One tolerated miss, then a second miss drops lock.
        send_frame(9'h0C0, 9'h111, 9'h122, 9'h133, 1'b1);
        chk("miss1_aligned", 36'(aligned), 36'h1);
        send(9'h133);
        chk("miss2_aligned", 36'(aligned), 36'h0);
        send(9'h101);
        send(9'h102);
        send(9'h103);
        chk("search_aligned", 36'(aligned), 36'h0);
        chk("hold_data", {out_data0, out_data1, out_data2, out_data3},
            {9'h0C0, 9'h111, 9'h122, 9'h133});
        send_frame(9'h1C0, 9'h144, 9'h155, 9'h166, 1'b1);
        chk("relock_aligned", 36'(aligned), 36'h1);

        // 5. Sync word on lane 2 is just data.
        send_frame(9'h1C0, 9'h101, 9'h1C0, 9'h103, 1'b1);
        chk("lane2_sync_aligned", 36'(aligned), 36'h1);
        send_frame(9'h1C0, 9'h1AA, 9'h0BB, 9'h1CC, 1'b1);

        // 6. Asynchronous reset mid-frame.
        send(9'h1C0);
        send(9'h1EE);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_aligned", 36'(aligned), 36'h0);
        chk("async_valid", 36'(out_valid), 36'h0);
        chk("async_data", {out_data0, out_data1, out_data2, out_data3}, 36'h0);
        send(9'h1DD);
        send(9'h1FF);
        @(negedge clk4f);
        reset_L = 1'b1;
        send_frame(9'h1C0, 9'h111, 9'h122, 9'h133, 1'b1);
        send(9'h100);
        send(9'h100);

        chk("scoreboard_empty", 36'(sb.size()), 36'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
